wash_sequencer: RTL and testbench

//  Parametrised next-generation washer controller: one clocked FSM sequencing fill, wash, drain,
//  N rinse passes, spin and done-alert, with a built-in down-counting stage timer.

---
 rtl/wash_sequencer_pkg.sv | 52 +++++
 rtl/wash_sequencer_if.sv | 34 +++
 rtl/wash_sequencer_stage_timer.sv | 36 +++
 rtl/wash_sequencer.sv | 129 ++++++++++++
 tb/tb_wash_sequencer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wash_sequencer_pkg.sv
// Shared definitions for the washer sequencer: stage codes, temp_sel bit
// positions and the per-stage actuator patterns.
package wash_pkg;

    // Stage codes as reported on the stage output.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FILL   = 4'd1,
        S_WASH   = 4'd2,
        S_DRAIN  = 4'd3,
        S_RFILL  = 4'd4,
        S_RINSE  = 4'd5,
        S_RDRAIN = 4'd6,
        S_SPIN   = 4'd7,
        S_DONE   = 4'd8
    } stage_e;

    // temp_sel = {cold, warm, hot}; cold is the fallback when neither hot nor
    // warm is set, so only these two positions are ever inspected.
    localparam int TEMP_HOT  = 0;
    localparam int TEMP_WARM = 1;

    // Actuator bundle, packed in the order {agitator, spin, pump, alert, cold, hot}.
    typedef struct packed {
        logic agitator;
        logic spin;
        logic pump;
        logic alert;
        logic cold_valve;
        logic hot_valve;
    } act_t;

    localparam act_t ACT_OFF     = 6'b000000;
    localparam act_t ACT_AGITATE = 6'b100000;
    localparam act_t ACT_DRAIN   = 6'b001000;
    localparam act_t ACT_SPIN    = 6'b011000;
    localparam act_t ACT_ALERT   = 6'b000100;
    localparam act_t ACT_COLD    = 6'b000010;
    localparam act_t ACT_HOT     = 6'b000001;
    localparam act_t ACT_BOTH    = 6'b000011;

    // Valve pattern for the main fill, hot taking priority over warm over cold.
    function automatic act_t fill_valves(input logic [2:0] temp);
        if (temp[TEMP_HOT])
            return ACT_HOT;
        else if (temp[TEMP_WARM])
            return ACT_BOTH;
        else
            return ACT_COLD;
    endfunction

endpackage

// File: rtl/wash_sequencer_if.sv
// Front-panel/sensor inputs and actuator/display outputs of the washer
// sequencer. The door_open signal exists only when DOOR_PAUSE_EN is defined.
interface wash_sequencer_if #(parameter int TIMER_W = 4);

    logic               start;
    logic               empty;
    logic               full;
    logic               extra_rinse;
    logic [2:0]         temp_sel;
`ifdef DOOR_PAUSE_EN
    logic               door_open;
`endif
    logic               agitator;
    logic               spin;
    logic               pump;
    logic               alert;
    logic               cold_valve;
    logic               hot_valve;
    logic [TIMER_W-1:0] timer;
    logic [3:0]         stage;

`ifdef DOOR_PAUSE_EN
    modport master (output start, empty, full, extra_rinse, temp_sel, door_open,
                    input  agitator, spin, pump, alert, cold_valve, hot_valve, timer, stage);
    modport slave  (input  start, empty, full, extra_rinse, temp_sel, door_open,
                    output agitator, spin, pump, alert, cold_valve, hot_valve, timer, stage);
`else
    modport master (output start, empty, full, extra_rinse, temp_sel,
                    input  agitator, spin, pump, alert, cold_valve, hot_valve, timer, stage);
    modport slave  (input  start, empty, full, extra_rinse, temp_sel,
                    output agitator, spin, pump, alert, cold_valve, hot_valve, timer, stage);
`endif

endinterface

// File: rtl/wash_sequencer_stage_timer.sv
// Down-counting stage timer: load wins, hold freezes, otherwise count down to 0.
module stage_timer #(
    parameter int TIMER_W = 4
) (
    input  logic               clock,
    input  logic               restart_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               hold,
    output logic [TIMER_W-1:0] count,
    output logic               last
);

    logic [TIMER_W-1:0] count_q, count_d;

    // Next count: reload on stage entry, freeze on hold, stop at zero.
    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (!hold && count_q != '0)
            count_d = count_q - TIMER_W'(1);
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (!restart_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;
    assign last  = (count_q == TIMER_W'(1));

endmodule

// File: rtl/wash_sequencer.sv
// Washer cycle sequencer: fill, wash, drain, N rinse passes, spin, done alert.
// Optional feature macro: DOOR_PAUSE_EN (adds door_open; an open door freezes
// the running stage, drops all actuators and raises alert).
module wash_sequencer
    import wash_pkg::*;
#(
    parameter int TIMER_W    = 4,
    parameter int WASH_TIME  = 9,
    parameter int RINSE_TIME = 6,
    parameter int SPIN_TIME  = 5,
    parameter int RINSES     = 1
) (
    input  logic              clock,
    input  logic              restart_n,
    wash_sequencer_if.slave   bus
);

    stage_e             state_q, state_d;
    logic [2:0]         temp_q, temp_d;
    logic               xr_q, xr_d;
    logic [3:0]         rcnt_q, rcnt_d;
    act_t               act_q, act_d;
    logic [3:0]         rinse_total;
    logic               pause;
    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_load_val;
    logic [TIMER_W-1:0] tmr_count;
    logic               tmr_last;

    assign rinse_total = 4'(RINSES) + {3'b000, xr_q};

`ifdef DOOR_PAUSE_EN
    assign pause = bus.door_open && (state_q != S_IDLE) && (state_q != S_DONE);
`else
    assign pause = 1'b0;
`endif

    stage_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clock     (clock),
        .restart_n (restart_n),
        .load      (tmr_load),
        .load_val  (tmr_load_val),
        .hold      (pause),
        .count     (tmr_count),
        .last      (tmr_last)
    );

    // State, latched settings, rinse counter and registered actuators.
    always_ff @(posedge clock) begin
        if (!restart_n) begin
            state_q <= S_IDLE;
            temp_q  <= '0;
            xr_q    <= 1'b0;
            rcnt_q  <= '0;
            act_q   <= ACT_OFF;
        end else begin
            state_q <= state_d;
            temp_q  <= temp_d;
            xr_q    <= xr_d;
            rcnt_q  <= rcnt_d;
            act_q   <= act_d;
        end
    end

    // Next state, settings capture, rinse counting and timer reload on stage entry.
    always_comb begin
        state_d = state_q;
        temp_d  = temp_q;
        xr_d    = xr_q;
        rcnt_d  = rcnt_q;
        if (!pause) begin
            case (state_q)
                S_IDLE, S_DONE: if (bus.start) begin
                    temp_d  = bus.temp_sel;
                    xr_d    = bus.extra_rinse;
                    rcnt_d  = '0;
                    state_d = S_FILL;
                end
                S_FILL:   if (bus.full)  state_d = S_WASH;
                S_WASH:   if (tmr_last)  state_d = S_DRAIN;
                S_DRAIN:  if (bus.empty) state_d = S_RFILL;
                S_RFILL:  if (bus.full)  state_d = S_RINSE;
                S_RINSE:  if (tmr_last)  state_d = S_RDRAIN;
                S_RDRAIN: if (bus.empty) begin
                    rcnt_d  = rcnt_q + 4'd1;
                    state_d = (rcnt_d < rinse_total) ? S_RFILL : S_SPIN;
                end
                S_SPIN:   if (tmr_last)  state_d = S_DONE;
                default:  state_d = S_IDLE;
            endcase
        end
        // Every stage change reloads the timer; untimed stages load zero.
        tmr_load = (state_d != state_q);
        case (state_d)
            S_WASH:  tmr_load_val = TIMER_W'(WASH_TIME);
            S_RINSE: tmr_load_val = TIMER_W'(RINSE_TIME);
            S_SPIN:  tmr_load_val = TIMER_W'(SPIN_TIME);
            default: tmr_load_val = '0;
        endcase
    end

    // Actuator pattern for the current stage, registered on the next edge.
    always_comb begin
        act_d = ACT_OFF;
        if (pause) begin
            act_d = ACT_ALERT;
        end else begin
            case (state_q)
                S_FILL:           act_d = fill_valves(temp_q);
                S_WASH, S_RINSE:  act_d = ACT_AGITATE;
                S_DRAIN, S_RDRAIN: act_d = ACT_DRAIN;
                S_RFILL:          act_d = ACT_COLD;
                S_SPIN:           act_d = ACT_SPIN;
                S_DONE:           act_d = ACT_ALERT;
                default:          act_d = ACT_OFF;
            endcase
        end
    end

    assign bus.agitator   = act_q.agitator;
    assign bus.spin       = act_q.spin;
    assign bus.pump       = act_q.pump;
    assign bus.alert      = act_q.alert;
    assign bus.cold_valve = act_q.cold_valve;
    assign bus.hot_valve  = act_q.hot_valve;
    assign bus.timer      = tmr_count;
    assign bus.stage      = state_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: builds a per-cycle expected trace of stage, timer
// and actuators from the washer's stage rules, then plays it against the DUT.
// Optional feature macro: DOOR_PAUSE_EN (exercises the door pause scenario).
module tb_wash_sequencer;

    localparam int TW = 4;
    localparam int WT = 9;
    localparam int RT = 6;
    localparam int ST = 5;
    localparam int NR = 2;

    localparam int S_IDLE = 0, S_FILL = 1, S_WASH = 2, S_DRAIN = 3, S_RFILL = 4;
    localparam int S_RINSE = 5, S_RDRAIN = 6, S_SPIN = 7, S_DONE = 8;

    typedef struct {
        int         st;
        int         tmr;
        bit         full;
        bit         empty;
        bit         start;
        bit         door;
        logic [2:0] temp;
        bit         xr;
    } cyc_t;

    logic clock = 1'b0;
    logic restart_n;
    always #5 clock = ~clock;

    wash_sequencer_if #(.TIMER_W(TW)) bus();

    wash_sequencer #(
        .TIMER_W(TW), .WASH_TIME(WT), .RINSE_TIME(RT), .SPIN_TIME(ST), .RINSES(NR)
    ) dut (
        .clock     (clock),
        .restart_n (restart_n),
        .bus       (bus)
    );

    cyc_t       plan[$];
    int         errors = 0;
    int         checks = 0;
    int         cur_st = S_IDLE;
    int         prev_st = S_IDLE;
    logic [2:0] prev_temp = 3'b000;
    bit         prev_pause = 1'b0;
    int         t4_idx = -1;

    function automatic logic [5:0] exp_acts(input int st, input logic [2:0] t);
        case (st)
            S_FILL:           return t[0] ? 6'b000001 : (t[1] ? 6'b000011 : 6'b000010);
            S_WASH, S_RINSE:  return 6'b100000;
            S_DRAIN, S_RDRAIN: return 6'b001000;
            S_RFILL:          return 6'b000010;
            S_SPIN:           return 6'b011000;
            S_DONE:           return 6'b000100;
            default:          return 6'b000000;
        endcase
    endfunction

    function automatic cyc_t mk(input int st, input int tmr, input bit last,
                                input logic [2:0] t, input bit xr, input bit with_start);
        cyc_t c;
        c.st    = st;
        c.tmr   = tmr;
        c.full  = (st == S_FILL || st == S_RFILL) ? last : 1'($urandom_range(0, 1));
        c.empty = (st == S_DRAIN || st == S_RDRAIN) ? last : 1'($urandom_range(0, 1));
        c.start = (st == S_IDLE || st == S_DONE) ? (with_start && last) : 1'($urandom_range(0, 1));
        c.door  = 1'b0;
        c.temp  = t;
        c.xr    = xr;
        return c;
    endfunction

    // Appends len cycles of one stage; timed stages count len..1.
    task automatic add_seg(input int st, input int len, input bit timed,
                           input logic [2:0] t, input bit xr, input bit with_start);
        for (int i = 0; i < len; i++)
            plan.push_back(mk(st, timed ? len - i : 0, i == len - 1, t, xr, with_start));
    endtask

    task automatic plan_wait(input int n);
        add_seg(cur_st, n, 1'b0, 3'b000, 1'b0, 1'b0);
    endtask

    // One complete wash cycle starting from the current resting stage.
    task automatic plan_cycle(input logic [2:0] t, input bit xr, input bit door_pause);
        cyc_t c;
        add_seg(cur_st, $urandom_range(1, 3), 1'b0, t, xr, 1'b1);
        add_seg(S_FILL, $urandom_range(1, 4), 1'b0, t, xr, 1'b0);
        for (int i = 0; i < WT; i++) begin
            if (door_pause && WT - i == 5) begin
                for (int j = 0; j < 10; j++) begin
                    c = mk(S_WASH, 5, 1'b0, t, xr, 1'b0);
                    c.door = 1'b1;
                    plan.push_back(c);
                end
            end
            if (WT - i == 4) t4_idx = plan.size();
            plan.push_back(mk(S_WASH, WT - i, 1'b0, t, xr, 1'b0));
        end
        add_seg(S_DRAIN, $urandom_range(1, 4), 1'b0, t, xr, 1'b0);
        for (int r = 0; r < NR + int'(xr); r++) begin
            add_seg(S_RFILL, $urandom_range(1, 4), 1'b0, t, xr, 1'b0);
            add_seg(S_RINSE, RT, 1'b1, t, xr, 1'b0);
            add_seg(S_RDRAIN, $urandom_range(1, 4), 1'b0, t, xr, 1'b0);
        end
        add_seg(S_SPIN, ST, 1'b1, t, xr, 1'b0);
        cur_st = S_DONE;
    endtask

    // Plays the planned trace; optionally asserts reset in cycle abort_at.
    task automatic play(input int abort_at);
        logic [5:0] exp_a, got_a;
        for (int k = 0; k < plan.size(); k++) begin
            @(negedge clock);
            exp_a = prev_pause ? 6'b000100 : exp_acts(prev_st, prev_temp);
            got_a = {bus.agitator, bus.spin, bus.pump, bus.alert, bus.cold_valve, bus.hot_valve};
            checks++;
            if (bus.stage !== 4'(plan[k].st)) begin
                errors++;
                $display("FAIL stage cyc=%0d got=%0d exp=%0d", k, bus.stage, plan[k].st);
            end
            checks++;
            if (bus.timer !== TW'(plan[k].tmr)) begin
                errors++;
                $display("FAIL timer cyc=%0d stage=%0d got=%0d exp=%0d", k, plan[k].st, bus.timer, plan[k].tmr);
            end
            checks++;
            if (got_a !== exp_a) begin
                errors++;
                $display("FAIL acts cyc=%0d stage=%0d got=%b exp=%b", k, plan[k].st, got_a, exp_a);
            end
            bus.full  = plan[k].full;
            bus.empty = plan[k].empty;
            bus.start = plan[k].start;
            if (plan[k].start && (plan[k].st == S_IDLE || plan[k].st == S_DONE)) begin
                bus.temp_sel    = plan[k].temp;
                bus.extra_rinse = plan[k].xr;
            end else begin
                bus.temp_sel    = 3'($urandom_range(0, 7));
                bus.extra_rinse = 1'($urandom_range(0, 1));
            end
`ifdef DOOR_PAUSE_EN
            bus.door_open = plan[k].door;
`endif
            prev_st    = plan[k].st;
            prev_temp  = plan[k].temp;
            prev_pause = plan[k].door;
            if (k == abort_at) begin
                restart_n = 1'b0;
                bus.start = 1'b1;
                @(negedge clock);
                got_a = {bus.agitator, bus.spin, bus.pump, bus.alert, bus.cold_valve, bus.hot_valve};
                checks++;
                if (bus.stage !== 4'd0 || bus.timer !== '0 || got_a !== 6'b0) begin
                    errors++;
                    $display("FAIL abort_reset stage=%0d timer=%0d acts=%b exp 0/0/000000",
                             bus.stage, bus.timer, got_a);
                end
                restart_n  = 1'b1;
                bus.start  = 1'b0;
                cur_st     = S_IDLE;
                prev_st    = S_IDLE;
                prev_pause = 1'b0;
                break;
            end
        end
        plan.delete();
    endtask

    task automatic test_reset();
        logic [5:0] got_a;
        restart_n       = 1'b0;
        bus.start       = 1'b1;
        bus.full        = 1'b1;
        bus.empty       = 1'b1;
        bus.extra_rinse = 1'b1;
        bus.temp_sel    = 3'b111;
`ifdef DOOR_PAUSE_EN
        bus.door_open   = 1'b0;
`endif
        repeat (3) @(negedge clock);
        got_a = {bus.agitator, bus.spin, bus.pump, bus.alert, bus.cold_valve, bus.hot_valve};
        checks++;
        if (bus.stage !== 4'd0) begin
            errors++;
            $display("FAIL reset_stage got=%0d exp=0", bus.stage);
        end
        checks++;
        if (bus.timer !== '0) begin
            errors++;
            $display("FAIL reset_timer got=%0d exp=0", bus.timer);
        end
        checks++;
        if (got_a !== 6'b0) begin
            errors++;
            $display("FAIL reset_acts got=%b exp=000000", got_a);
        end
        restart_n = 1'b1;
        bus.start = 1'b0;
        cur_st    = S_IDLE;
        prev_st   = S_IDLE;
    endtask

    task automatic test_basic_hot();
        plan_cycle(3'b001, 1'b0, 1'b0);
        plan_wait(4);
        play(-1);
    endtask

    task automatic test_extra_rinse();
        plan_cycle(3'($urandom_range(0, 7)), 1'b1, 1'b0);
        play(-1);
    endtask

    task automatic test_temps();
        plan_cycle(3'b010, 1'b0, 1'b0);
        plan_cycle(3'b000, 1'b1, 1'b0);
        plan_cycle(3'b100, 1'b0, 1'b0);
        play(-1);
    endtask

    task automatic test_reset_mid_wash();
        plan_cycle(3'b001, 1'b1, 1'b0);
        play(t4_idx);
        plan_cycle(3'b010, 1'b0, 1'b0);
        plan_wait(2);
        play(-1);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++)
            plan_cycle(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
        plan_wait(3);
        play(-1);
    endtask

`ifdef DOOR_PAUSE_EN
    task automatic test_door_pause();
        plan_cycle(3'b001, 1'b0, 1'b1);
        plan_wait(2);
        play(-1);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_hot();
        test_extra_rinse();
        test_temps();
        test_reset_mid_wash();
        test_back_to_back();
`ifdef DOOR_PAUSE_EN
        test_door_pause();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
